// File: rtl/toggle_pulse_gen.sv
// toggle_pulse_gen
// Conditions a raw, bouncing push-button level into exactly one single-cycle
// t_pulse per accepted press, suitable for driving a T flip-flop directly.
// The input is synchronised through two flops and then debounced in both
// directions. The block also exposes the debounced level and a wrapping
// 8-bit count of emitted pulses.
//
// Optional feature: define TOGGLE_AUTO_REPEAT_EN to emit repeat pulses every
// REPEAT_CYCLES cycles while the button stays held. When the macro is not
// defined, no repeat logic is built and REPEAT_CYCLES has no effect.
module toggle_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   output logic       t_pulse,
   output logic       btn_level,
   output logic [7:0] pulse_count
);

   typedef enum logic [1:0] {
      ST_LOW      = 2'd0,
      ST_RISE_CHK = 2'd1,
      ST_HIGH     = 2'd2,
      ST_FALL_CHK = 2'd3
   } state_t;

   localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES);

   // Stop elaboration on parameter values outside the legal range.
   if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 255)) begin : g_bad_debounce
      $error("toggle_pulse_gen: DEBOUNCE_CYCLES must be 1..255");
   end
   if ((REPEAT_CYCLES < 2) || (REPEAT_CYCLES > 255)) begin : g_bad_repeat
      $error("toggle_pulse_gen: REPEAT_CYCLES must be 2..255");
   end

   logic   sync0_r;
   logic   sync1_r;
   state_t state_r;
   logic [7:0] cnt_r;

`ifdef TOGGLE_AUTO_REPEAT_EN
   localparam logic [7:0] REP_LAST = 8'(REPEAT_CYCLES - 1);
   logic [7:0] rcnt_r;
`endif

   // Two-flop synchroniser; only sync1_r is used by the debouncer.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync0_r <= 1'b0;
         sync1_r <= 1'b0;
      end else begin
         sync0_r <= btn_in;
         sync1_r <= sync0_r;
      end
   end

   // Debounce FSM with registered pulse, level and press counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_LOW;
         cnt_r       <= 8'd0;
         t_pulse     <= 1'b0;
         btn_level   <= 1'b0;
         pulse_count <= 8'd0;
`ifdef TOGGLE_AUTO_REPEAT_EN
         rcnt_r      <= 8'd0;
`endif
      end else begin
         t_pulse <= 1'b0;
         case (state_r)
            ST_LOW: begin
               btn_level <= 1'b0;
               if (sync1_r) begin
                  state_r <= ST_RISE_CHK;
                  cnt_r   <= 8'd1;
               end else begin
                  state_r <= ST_LOW;
                  cnt_r   <= 8'd0;
               end
            end
            ST_RISE_CHK: begin
               if (!sync1_r) begin
                  // bounce: fall back without a pulse
                  state_r   <= ST_LOW;
                  cnt_r     <= 8'd0;
                  btn_level <= 1'b0;
               end else if (cnt_r == DEB_LAST) begin
                  state_r     <= ST_HIGH;
                  cnt_r       <= 8'd0;
                  btn_level   <= 1'b1;
                  t_pulse     <= 1'b1;
                  pulse_count <= pulse_count + 8'd1;
`ifdef TOGGLE_AUTO_REPEAT_EN
                  rcnt_r      <= 8'd0;
`endif
               end else begin
                  cnt_r     <= cnt_r + 8'd1;
                  btn_level <= 1'b0;
               end
            end
            ST_HIGH: begin
               btn_level <= 1'b1;
               if (!sync1_r) begin
                  state_r <= ST_FALL_CHK;
                  cnt_r   <= 8'd1;
               end else begin
                  state_r <= ST_HIGH;
                  cnt_r   <= 8'd0;
`ifdef TOGGLE_AUTO_REPEAT_EN
                  // held: emit a repeat pulse every REPEAT_CYCLES cycles
                  if (rcnt_r == REP_LAST) begin
                     rcnt_r      <= 8'd0;
                     t_pulse     <= 1'b1;
                     pulse_count <= pulse_count + 8'd1;
                  end else begin
                     rcnt_r <= rcnt_r + 8'd1;
                  end
`endif
               end
            end
            ST_FALL_CHK: begin
               if (sync1_r) begin
                  // release glitch: back to HIGH, no pulse
                  state_r   <= ST_HIGH;
                  cnt_r     <= 8'd0;
                  btn_level <= 1'b1;
`ifdef TOGGLE_AUTO_REPEAT_EN
                  rcnt_r    <= 8'd0;
`endif
               end else if (cnt_r == DEB_LAST) begin
                  state_r   <= ST_LOW;
                  cnt_r     <= 8'd0;
                  btn_level <= 1'b0;
               end else begin
                  cnt_r     <= cnt_r + 8'd1;
                  btn_level <= 1'b1;
               end
            end
            default: begin
               state_r   <= ST_LOW;
               cnt_r     <= 8'd0;
               btn_level <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed self-checking bench for toggle_pulse_gen (DEBOUNCE_CYCLES=4,
// REPEAT_CYCLES=8). Expected repeat behaviour follows TOGGLE_AUTO_REPEAT_EN.
module tb_toggle_pulse_gen;

   logic       clk;
   logic       rst;
   logic       btn_in;
   logic       t_pulse;
   logic       btn_level;
   logic [7:0] pulse_count;

   int n_checks = 0;
   int n_fail   = 0;

   // per-segment observations, gathered one cycle at a time
   int   seg_tick;
   int   seg_pulses;
   int   seg_first;
   int   seg_low_at;
   logic seg_hi;
   logic seg_lo;
   int   consec;
   logic prev_pulse;
   logic q_model;

`ifdef TOGGLE_AUTO_REPEAT_EN
   localparam int EXP_REP = 4;
`else
   localparam int EXP_REP = 1;
`endif

   toggle_pulse_gen #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_CYCLES   (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in),
      .t_pulse     (t_pulse),
      .btn_level   (btn_level),
      .pulse_count (pulse_count)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // run-time guard
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic seg_start();
      seg_tick   = 0;
      seg_pulses = 0;
      seg_first  = 0;
      seg_low_at = 0;
      seg_hi     = 1'b0;
      seg_lo     = 1'b0;
   endtask

   // advance one clock and sample outputs 1 unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      seg_tick++;
      if (t_pulse) begin
         seg_pulses++;
         if (seg_first == 0) seg_first = seg_tick;
         q_model = ~q_model;
         if (prev_pulse) consec++;
      end
      prev_pulse = t_pulse;
      if (btn_level) seg_hi = 1'b1;
      else begin
         seg_lo = 1'b1;
         if (seg_low_at == 0) seg_low_at = seg_tick;
      end
   endtask

   task automatic drive(input logic lvl, input int n);
      btn_in = lvl;
      repeat (n) tick();
   endtask

   initial begin
      rst        = 1'b1;
      btn_in     = 1'b0;
      consec     = 0;
      prev_pulse = 1'b0;
      q_model    = 1'b0;
      seg_start();

      // reset held 3 cycles with a toggling input
      for (int i = 0; i < 3; i++) begin
         btn_in = ~btn_in;
         tick();
         check("rst_t_pulse", 32'(t_pulse), 32'd0);
         check("rst_level", 32'(btn_level), 32'd0);
         check("rst_count", 32'(pulse_count), 32'd0);
      end
      btn_in = 1'b0;
      rst    = 1'b0;
      tick();
      check("post_rst_t_pulse", 32'(t_pulse), 32'd0);
      check("post_rst_level", 32'(btn_level), 32'd0);
      check("post_rst_count", 32'(pulse_count), 32'd0);
      drive(1'b0, 3);

      // clean press: pulse in the cycle after edge N+6
      seg_start();
      drive(1'b1, 10);
      check("press_first_pulse_at", 32'(seg_first), 32'd7);
      check("press_pulses", 32'(seg_pulses), 32'd1);
      check("press_count", 32'(pulse_count), 32'd1);
      check("press_level", 32'(btn_level), 32'd1);
      check("press_tff_q", 32'(q_model), 32'd1);
      seg_start();
      drive(1'b0, 10);
      check("release_level_fall_at", 32'(seg_low_at), 32'd7);
      check("release_pulses", 32'(seg_pulses), 32'd0);

      // bounce shorter than the debounce window
      seg_start();
      drive(1'b1, 2);
      drive(1'b0, 1);
      drive(1'b1, 2);
      drive(1'b0, 10);
      check("bounce_pulses", 32'(seg_pulses), 32'd0);
      check("bounce_level_seen_high", 32'(seg_hi), 32'd0);
      check("bounce_count", 32'(pulse_count), 32'd1);

      // release glitch while HIGH
      drive(1'b1, 10);
      check("glitch_setup_count", 32'(pulse_count), 32'd2);
      seg_start();
      drive(1'b0, 2);
      drive(1'b1, 8);
      check("glitch_level_dropped", 32'(seg_lo), 32'd0);
      check("glitch_pulses", 32'(seg_pulses), 32'd0);
      drive(1'b0, 10);
      check("glitch_count", 32'(pulse_count), 32'd2);
      check("glitch_final_level", 32'(btn_level), 32'd0);

      // counter wrap: 254 more presses bring 2 back round to 0
      seg_start();
      for (int i = 0; i < 254; i++) begin
         drive(1'b1, 8);
         drive(1'b0, 8);
      end
      check("wrap_pulses", 32'(seg_pulses), 32'd254);
      check("wrap_count_zero", 32'(pulse_count), 32'd0);
      drive(1'b1, 8);
      drive(1'b0, 8);
      check("wrap_count_one", 32'(pulse_count), 32'd1);

      // long hold: repeats only when the feature is built
      seg_start();
      drive(1'b1, 35);
      check("hold_first_pulse_at", 32'(seg_first), 32'd7);
      drive(1'b0, 10);
      check("hold_pulses", 32'(seg_pulses), 32'(EXP_REP));
      check("hold_count", 32'(pulse_count), 32'(1 + EXP_REP));
      check("no_back_to_back", 32'(consec), 32'd0);

      // reset on the edge that would carry the first repeat pulse
      seg_start();
      drive(1'b1, 14);
      check("rr_first_pulse_at", 32'(seg_first), 32'd7);
      rst = 1'b1;
      tick();
      check("rr_t_pulse", 32'(t_pulse), 32'd0);
      check("rr_count", 32'(pulse_count), 32'd0);
      check("rr_level", 32'(btn_level), 32'd0);
      rst = 1'b0;

      // reset part-way through the rise debounce discards it
      drive(1'b1, 4);
      rst = 1'b1;
      tick();
      check("mid_rise_rst_count", 32'(pulse_count), 32'd0);
      rst = 1'b0;
      seg_start();
      drive(1'b1, 10);
      check("mid_rise_restart_at", 32'(seg_first), 32'd7);
      check("mid_rise_count", 32'(pulse_count), 32'd1);
      drive(1'b0, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
